fwperiph_dma_wb_arbiter: RTL and testbench

- Round-robin arbiter sharing one Wishbone (classic, non-pipelined) initiator port among N requesters, e.g. DMA channel engines and the register-side initiator.
- Grant is held for the whole bus cycle (i_cyc high), so multi-beat transfers and read-modify-write sequences are atomic.
- Sits between the DMA channel initiators and the single system-bus Wishbone initiator that the wb agent monitors and responds to.

---
 rtl/fwperiph_dma_wb_arbiter_if.sv | 38 +++
 rtl/fwperiph_dma_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_fwperiph_dma_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwperiph_dma_wb_arbiter_if.sv
// rtl/fwperiph_dma_wb_arbiter_if.sv - Wishbone arbiter bus bundle: N initiator slices plus one target port
interface fwperiph_dma_wb_arbiter_if #(
  parameter int N_INITIATORS = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic [N_INITIATORS*ADDR_WIDTH-1:0] i_adr;
  logic [N_INITIATORS*DATA_WIDTH-1:0] i_dat_w;
  logic [N_INITIATORS*SW-1:0]         i_sel;
  logic [N_INITIATORS-1:0]            i_cyc;
  logic [N_INITIATORS-1:0]            i_stb;
  logic [N_INITIATORS-1:0]            i_we;
  logic [DATA_WIDTH-1:0]              i_dat_r;
  logic [N_INITIATORS-1:0]            i_ack;
  logic [N_INITIATORS-1:0]            i_err;
  logic [ADDR_WIDTH-1:0]              t_adr;
  logic [DATA_WIDTH-1:0]              t_dat_w;
  logic [SW-1:0]                      t_sel;
  logic                               t_cyc;
  logic                               t_stb;
  logic                               t_we;
  logic [DATA_WIDTH-1:0]              t_dat_r;
  logic                               t_ack;
  logic                               t_err;
  logic [N_INITIATORS-1:0]            gnt;

  modport slave (
    input  i_adr, i_dat_w, i_sel, i_cyc, i_stb, i_we, t_dat_r, t_ack, t_err,
    output i_dat_r, i_ack, i_err, t_adr, t_dat_w, t_sel, t_cyc, t_stb, t_we, gnt
  );

  modport master (
    output i_adr, i_dat_w, i_sel, i_cyc, i_stb, i_we, t_dat_r, t_ack, t_err,
    input  i_dat_r, i_ack, i_err, t_adr, t_dat_w, t_sel, t_cyc, t_stb, t_we, gnt
  );
endinterface

// File: rtl/fwperiph_dma_wb_arbiter.sv
// rtl/fwperiph_dma_wb_arbiter.sv - round-robin Wishbone classic arbiter, grant held for the whole bus cycle
// Optional stalled-target watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module fwperiph_dma_wb_arbiter #(
  parameter int N_INITIATORS   = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                     clock,
  input logic                     reset,
  fwperiph_dma_wb_arbiter_if.slave bus
);
  localparam int N  = N_INITIATORS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win, idx;
  logic            found;
  logic            granted;
  logic            cyc_g;
  logic            to_hit;

  assign granted = (state_q == ST_GRANT);

  // The holder's own i_cyc is low whenever we re-arbitrate, so it only wins again when alone.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_q) + k) % N);
      if (!found && bus.i_cyc[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          gnt_d   = N'(1) << win;
          last_d  = win;
        end
      end
      ST_GRANT: begin
        if (!bus.i_cyc[last_q]) begin
          if (found) begin
            gnt_d  = N'(1) << win;
            last_d = win;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          stall;

  assign stall  = granted & bus.i_cyc[last_q] & bus.i_stb[last_q] & ~bus.t_ack & ~bus.t_err;
  assign to_hit = stall && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign to_cnt_d = (stall && !to_hit) ? to_cnt_q + 1'b1 : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // TIMEOUT_CYCLES has no effect in this build; the expression is constant false.
  assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Pure combinational path from the registered grant: no added wait states.
  always_comb begin
    cyc_g       = granted & bus.i_cyc[last_q];
    bus.t_cyc   = cyc_g;
    bus.t_stb   = 1'b0;
    bus.t_we    = 1'b0;
    bus.t_adr   = '0;
    bus.t_dat_w = '0;
    bus.t_sel   = '0;
    bus.i_ack   = '0;
    bus.i_err   = '0;
    if (granted) begin
      bus.t_stb   = bus.i_stb[last_q] & ~to_hit;
      bus.t_we    = bus.i_we[last_q];
      bus.t_adr   = bus.i_adr[last_q*ADDR_WIDTH +: ADDR_WIDTH];
      bus.t_dat_w = bus.i_dat_w[last_q*DATA_WIDTH +: DATA_WIDTH];
      bus.t_sel   = bus.i_sel[last_q*SW +: SW];
      bus.i_ack[last_q] = bus.t_ack & cyc_g;
      bus.i_err[last_q] = (bus.t_err & cyc_g) | to_hit;
    end
  end

  assign bus.i_dat_r = bus.t_dat_r;
  assign bus.gnt     = gnt_q;
endmodule

// File: tb/tb_fwperiph_dma_wb_arbiter.sv
// tb/tb_fwperiph_dma_wb_arbiter.sv - scoreboard bench for the round-robin Wishbone arbiter
module tb_fwperiph_dma_wb_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
  localparam logic [31:0] RD_KEY = 32'h5A5A_5A5A;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fwperiph_dma_wb_arbiter_if #(.N_INITIATORS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fwperiph_dma_wb_arbiter #(
    .N_INITIATORS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic          cyc_r [N];
  logic          stb_r [N];
  logic          we_r  [N];
  logic [AW-1:0] adr_r [N];
  logic [DW-1:0] dat_r [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      bus.i_cyc[k]              = cyc_r[k];
      bus.i_stb[k]              = stb_r[k];
      bus.i_we[k]               = we_r[k];
      bus.i_adr[k*AW +: AW]     = adr_r[k];
      bus.i_dat_w[k*DW +: DW]   = dat_r[k];
      bus.i_sel[k*SW +: SW]     = '1;
    end
  end

  // Target read data is a fixed function of the address so reads can be predicted.
  always_comb bus.t_dat_r = bus.t_adr ^ RD_KEY;

  int n_checks = 0;
  int n_fail   = 0;
  int gnt_exp[$];
  int resp_mode;
  int lat;
  bit e [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1) << k;
  endfunction

  // Target responder: ack (or err) lat cycles after a strobe is seen, one cycle wide.
  initial begin
    int cnt;
    cnt = 0;
    bus.t_ack = 1'b0;
    bus.t_err = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (bus.t_ack || bus.t_err) begin
        bus.t_ack = 1'b0;
        bus.t_err = 1'b0;
        cnt = 0;
      end else if (bus.t_cyc && bus.t_stb && resp_mode != 2) begin
        cnt++;
        if (cnt >= lat) begin
          if (resp_mode == 1) begin
            bus.t_err = 1'b1;
            resp_mode = 0;
          end else begin
            bus.t_ack = 1'b1;
          end
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Grant monitor: every new non-zero grant must match the next expected winner.
  initial begin
    logic [N-1:0] prev;
    int exp_i;
    prev = '0;
    forever begin
      @(negedge clock);
      if (bus.gnt !== prev && bus.gnt != '0) begin
        if (gnt_exp.size() == 0) begin
          chk("gnt_unexpected", 64'(bus.gnt), 64'd0);
        end else begin
          exp_i = gnt_exp.pop_front();
          chk("gnt_order", 64'(bus.gnt), 64'(onehot(exp_i)));
        end
      end
      prev = bus.gnt;
    end
  end

  task automatic wb_cycle(input int k, input logic [31:0] adr, input logic [31:0] dat,
                          input logic we, input int beats, output bit got_err);
    int w;
    bit timed_out;
    got_err   = 1'b0;
    timed_out = 1'b0;
    adr_r[k] = adr;
    dat_r[k] = dat;
    we_r[k]  = we;
    cyc_r[k] = 1'b1;
    stb_r[k] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      adr_r[k] = adr + 32'(4 * b);
      dat_r[k] = dat + 32'(b);
      w = 0;
      @(negedge clock);
      while (!(bus.i_ack[k] || bus.i_err[k]) && w < 200) begin
        @(negedge clock);
        w++;
      end
      if (!(bus.i_ack[k] || bus.i_err[k])) begin
        chk("resp_timeout", 64'd0, 64'd1);
        timed_out = 1'b1;
        break;
      end
      chk("ack_onehot", 64'(bus.i_ack & ~onehot(k)), 64'd0);
      chk("gnt_hold", 64'(bus.gnt), 64'(onehot(k)));
      chk("t_adr", 64'(bus.t_adr), 64'(adr + 32'(4 * b)));
      chk("t_we", 64'(bus.t_we), 64'(we));
      if (bus.i_err[k]) begin
        chk("err_no_ack", 64'(bus.i_ack[k]), 64'd0);
        got_err = 1'b1;
        @(posedge clock);
        #1;
        break;
      end
      if (we) chk("t_dat_w", 64'(bus.t_dat_w), 64'(dat + 32'(b)));
      else    chk("rd_data", 64'(bus.i_dat_r), 64'((adr + 32'(4 * b)) ^ RD_KEY));
      @(posedge clock);
      #1;
    end
    cyc_r[k] = 1'b0;
    stb_r[k] = 1'b0;
    if (!timed_out) begin
      @(posedge clock);
      #1;
      chk("release_1edge", 64'(bus.gnt[k]), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, first, pulses, bad;
    logic stb_at;
    for (int k = 0; k < N; k++) begin
      cyc_r[k] = 1'b0; stb_r[k] = 1'b0; we_r[k] = 1'b0; adr_r[k] = '0; dat_r[k] = '0;
    end
    resp_mode = 0;
    lat = 2;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_t_cyc", 64'(bus.t_cyc), 64'd0);
    chk("rst_t_stb", 64'(bus.t_stb), 64'd0);
    chk("rst_i_ack", 64'(bus.i_ack), 64'd0);
    chk("rst_i_err", 64'(bus.i_err), 64'd0);
    chk("rst_t_adr", 64'(bus.t_adr), 64'd0);
    chk("rst_t_we", 64'(bus.t_we), 64'd0);
    reset = 1'b1;

    // Single requester
    @(posedge clock); #1;
    gnt_exp.push_back(2);
    fork
      wb_cycle(2, 32'h1000_0040, 32'hDEAD_BEEF, 1'b1, 1, e[2]);
      begin @(posedge clock); #1; chk("gnt_latency", 64'(bus.gnt), 64'h4); end
    join

    // All four out of reset
    reset = 1'b0; @(posedge clock); #1; reset = 1'b1; @(posedge clock); #1;
    for (int k = 0; k < N; k++) gnt_exp.push_back(k);
    fork
      wb_cycle(0, 32'h0000_0100, 32'h0000_0A00, 1'b1, 1, e[0]);
      wb_cycle(1, 32'h0000_0200, 32'h0000_0B00, 1'b0, 1, e[1]);
      wb_cycle(2, 32'h0000_0300, 32'h0000_0C00, 1'b1, 1, e[2]);
      wb_cycle(3, 32'h0000_0400, 32'h0000_0D00, 1'b0, 1, e[3]);
    join

    // Multi-beat hold with a competing requester
    @(posedge clock); #1;
    gnt_exp.push_back(1);
    gnt_exp.push_back(3);
    fork
      begin
        wb_cycle(1, 32'h2000_0100, 32'h0, 1'b0, 4, e[1]);
        chk("gnt_to_3", 64'(bus.gnt), 64'h8);
      end
      begin
        repeat (3) @(posedge clock); #1;
        wb_cycle(3, 32'h3000_0000, 32'h0000_3333, 1'b1, 1, e[3]);
      end
    join

    // Target error on a read
    @(posedge clock); #1;
    resp_mode = 1;
    gnt_exp.push_back(0);
    gnt_exp.push_back(2);
    fork
      begin
        wb_cycle(0, 32'h4000_0000, 32'h0, 1'b0, 1, e[0]);
        chk("err_seen", 64'(e[0]), 64'd1);
      end
      begin
        @(posedge clock); #1;
        wb_cycle(2, 32'h4000_0020, 32'h0000_0022, 1'b1, 1, e[2]);
        chk("no_err_2", 64'(e[2]), 64'd0);
      end
    join

    // Reset mid-beat with ack pending
    @(posedge clock); #1;
    gnt_exp.push_back(1);
    adr_r[1] = 32'h5000_0000; we_r[1] = 1'b0; cyc_r[1] = 1'b1; stb_r[1] = 1'b1;
    w = 0;
    @(negedge clock);
    while (!bus.i_ack[1] && w < 50) begin @(negedge clock); w++; end
    chk("rst_ack_seen", 64'(bus.i_ack[1]), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_t_cyc", 64'(bus.t_cyc), 64'd0);
    chk("midrst_gnt", 64'(bus.gnt), 64'd0);
    chk("midrst_i_ack", 64'(bus.i_ack), 64'd0);
    cyc_r[1] = 1'b0; stb_r[1] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    gnt_exp.push_back(0);
    gnt_exp.push_back(3);
    fork
      wb_cycle(3, 32'h6000_0000, 32'h0000_0063, 1'b1, 1, e[3]);
      wb_cycle(0, 32'h6000_0010, 32'h0000_0060, 1'b1, 1, e[0]);
      begin @(posedge clock); #1; chk("rst_prio", 64'(bus.gnt), 64'h1); end
    join

    // Stalled target
    @(posedge clock); #1;
    resp_mode = 2;
    gnt_exp.push_back(2);
    adr_r[2] = 32'h7000_0000; we_r[2] = 1'b0; cyc_r[2] = 1'b1; stb_r[2] = 1'b1;
    @(posedge clock); #1;
`ifdef WB_ARB_TIMEOUT_EN
    first = 0; pulses = 0; stb_at = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (bus.i_err[2]) begin
        pulses++;
        if (first == 0) begin first = c; stb_at = bus.t_stb; end
      end
    end
    chk("to_cycle", 64'(first), 64'(TO));
    chk("to_stb_low", 64'(stb_at), 64'd0);
    chk("to_one_pulse", 64'(pulses), 64'd1);
`else
    bad = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clock);
      if (bus.gnt !== 4'b0100 || bus.t_stb !== 1'b1 || bus.i_err !== '0) bad++;
    end
    chk("grant_persist", 64'(bad), 64'd0);
`endif
    cyc_r[2] = 1'b0; stb_r[2] = 1'b0;
    resp_mode = 0;
    @(posedge clock); #1;
    chk("stall_release", 64'(bus.gnt), 64'd0);

    repeat (3) @(posedge clock);
    chk("sb_drain", 64'(gnt_exp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
